// File: rtl/issue_sched_pkg.sv
// Shared types for the issue scheduler: register index and decoded slot record.
// No logic here; latency and backpressure are defined by the users of these types.
package issue_sched_pkg;

  localparam int REG_W = 8;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     wr;
    logic     use1;
    logic     use2;
  } slot_t;

  // Register x0 is hardwired, so it never creates a dependency.
  function automatic logic hit(reg_idx_t a, logic a_en, reg_idx_t b, logic b_en);
    return a_en && b_en && (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight destination scoreboard: set on issue, clear on writeback, set wins.
// Updates one edge after the request; x0 is never tracked; no backpressure.
module reg_scoreboard
  import issue_sched_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int LANES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         i_set_en,
  input  logic [LANES*REG_W-1:0]   i_set_idx,
  input  logic [LANES-1:0]         i_clr_en,
  input  logic [LANES*REG_W-1:0]   i_clr_idx,
  output logic [NREGS-1:0]         o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int k = 0; k < LANES; k++) begin
        if (i_set_en[k] && (i_set_idx[k*REG_W +: REG_W] == reg_idx_t'(r))) w_set[r] = 1'b1;
        if (i_clr_en[k] && (i_clr_idx[k*REG_W +: REG_W] == reg_idx_t'(r))) w_clr[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/issue_scheduler.sv
// N-lane issue scheduler: holds one bundle, issues each slot once its register hazards clear.
// Issue 1 cycle after accept; in_ready drops while any held slot stays blocked past this cycle.
module issue_scheduler
  import issue_sched_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int NREGS        = 32,
  parameter int STRICT_ORDER = 1,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES-1:0]               in_slot_valid,
  input  logic [LANES*$clog2(NREGS)-1:0] in_rd,
  input  logic [LANES*$clog2(NREGS)-1:0] in_rs1,
  input  logic [LANES*$clog2(NREGS)-1:0] in_rs2,
  input  logic [LANES-1:0]               in_wr,
  input  logic [LANES-1:0]               in_use1,
  input  logic [LANES-1:0]               in_use2,
  input  logic                           flush,
  output logic [LANES-1:0]               issue,
  output logic [LANES-1:0]               freeze,
  input  logic [LANES-1:0]               wb_valid,
  input  logic [LANES*$clog2(NREGS)-1:0] wb_rd,
  output logic [NREGS-1:0]               busy,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int RW = $clog2(NREGS);

  slot_t                  r_slot [LANES];
  slot_t                  w_in_slot [LANES];
  logic [LANES-1:0]       r_pend;
  logic [CNT_W-1:0]       r_stall_cnt;
  logic [LANES-1:0]       w_elig;
  logic [LANES-1:0]       w_issue;
  logic                   w_accept;
  logic [NREGS-1:0]       w_busy;
  logic [LANES-1:0]       w_set_en;
  logic [LANES*REG_W-1:0] w_set_idx;
  logic [LANES*REG_W-1:0] w_clr_idx;

  function automatic logic reg_busy(logic [NREGS-1:0] vec, reg_idx_t idx, logic en);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (en && (idx != '0) && (idx == reg_idx_t'(r)) && vec[r]) b = 1'b1;
    end
    return b;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic             w_src_ok;
    logic             w_older_ok;
    logic             w_ok;
    logic [LANES-1:0] w_pair;

    assign w_in_slot[i] = '{rd:   reg_idx_t'(in_rd[i*RW +: RW]),
                            rs1:  reg_idx_t'(in_rs1[i*RW +: RW]),
                            rs2:  reg_idx_t'(in_rs2[i*RW +: RW]),
                            wr:   in_wr[i],
                            use1: in_use1[i],
                            use2: in_use2[i]};

    assign w_src_ok = !reg_busy(w_busy, r_slot[i].rs1, r_slot[i].use1) &&
                      !reg_busy(w_busy, r_slot[i].rs2, r_slot[i].use2) &&
                      !reg_busy(w_busy, r_slot[i].rd,  r_slot[i].wr);

    // RAW, WAW and WAR against every older slot still held.
    for (genvar j = 0; j < LANES; j++) begin : g_pair
      if (j < i) begin : g_older
        assign w_pair[j] = r_pend[j] & (
            hit(r_slot[j].rd, r_slot[j].wr, r_slot[i].rs1, r_slot[i].use1) |
            hit(r_slot[j].rd, r_slot[j].wr, r_slot[i].rs2, r_slot[i].use2) |
            hit(r_slot[j].rd, r_slot[j].wr, r_slot[i].rd,  r_slot[i].wr)   |
            hit(r_slot[i].rd, r_slot[i].wr, r_slot[j].rs1, r_slot[j].use1) |
            hit(r_slot[i].rd, r_slot[i].wr, r_slot[j].rs2, r_slot[j].use2));
      end else begin : g_none
        assign w_pair[j] = 1'b0;
      end
    end

    if (i == 0) begin : g_first
      assign w_older_ok = 1'b1;
    end else begin : g_chain
      assign w_older_ok = g_lane[i-1].w_older_ok & (~r_pend[i-1] | g_lane[i-1].w_ok);
    end

    assign w_ok      = r_pend[i] & w_src_ok & ~|w_pair & ((STRICT_ORDER == 0) | w_older_ok);
    assign w_elig[i] = w_ok;

    assign w_set_en[i]                  = w_issue[i] & r_slot[i].wr;
    assign w_set_idx[i*REG_W +: REG_W]  = r_slot[i].rd;
    assign w_clr_idx[i*REG_W +: REG_W]  = reg_idx_t'(wb_rd[i*RW +: RW]);
  end

  assign w_issue  = w_elig & {LANES{~flush}};
  assign issue    = w_issue;
  assign freeze   = r_pend & ~w_elig;
  assign in_ready = ~|(r_pend & ~w_issue) | flush;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_stall_cnt <= '0;
      for (int i = 0; i < LANES; i++) r_slot[i] <= '0;
    end else begin
      if (w_accept) begin
        r_pend <= in_slot_valid;
        for (int i = 0; i < LANES; i++) r_slot[i] <= w_in_slot[i];
      end else if (flush) begin
        r_pend <= '0;
      end else begin
        r_pend <= r_pend & ~w_issue;
      end
      if (|freeze && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  reg_scoreboard #(.NREGS(NREGS), .LANES(LANES)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (w_set_en),
    .i_set_idx (w_set_idx),
    .i_clr_en  (wb_valid),
    .i_clr_idx (w_clr_idx),
    .o_busy    (w_busy)
  );

  assign busy      = w_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench: strict-order and bypass instances share stimulus; per-cycle table plus corner sequences.
module tb_issue_scheduler;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr;
    logic       u1;
    logic       u2;
  } tslot_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  sv;
    tslot_t      s0;
    tslot_t      s1;
    logic        fl;
    logic [1:0]  wbv;
    logic [4:0]  wb0;
    logic [4:0]  wb1;
    logic [1:0]  e_iss;
    logic [1:0]  e_frz;
    logic        e_rdy;
    logic [31:0] e_busy;
    logic [5:0]  e_cnt;
    logic [1:0]  e_issb;
    logic [1:0]  e_frzb;
  } vec_t;

  localparam tslot_t NOP = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_slot_valid = '0;
  logic [9:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [1:0]  in_wr = '0, in_use1 = '0, in_use2 = '0;
  logic        flush = 1'b0;
  logic [1:0]  wb_valid = '0;
  logic [9:0]  wb_rd = '0;

  logic        in_ready, in_ready_b;
  logic [1:0]  issue, freeze, issue_b, freeze_b;
  logic [31:0] busy, busy_b;
  logic [5:0]  stall_cnt, stall_cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl [11];

  always #5 clk = ~clk;

  issue_scheduler #(.LANES(2), .NREGS(32), .STRICT_ORDER(1), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_wr(in_wr), .in_use1(in_use1), .in_use2(in_use2), .flush(flush),
    .issue(issue), .freeze(freeze), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  issue_scheduler #(.LANES(2), .NREGS(32), .STRICT_ORDER(0), .CNT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_slot_valid(in_slot_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_wr(in_wr), .in_use1(in_use1), .in_use2(in_use2), .flush(flush),
    .issue(issue_b), .freeze(freeze_b), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy(busy_b), .stall_cnt(stall_cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tslot_t mk(input int rd, input int rs1, input int rs2,
                                input logic wr, input logic u1, input logic u2);
    return '{5'(rd), 5'(rs1), 5'(rs2), wr, u1, u2};
  endfunction

  function automatic tslot_t add(input int rd, input int rs1, input int rs2);
    return mk(rd, rs1, rs2, 1'b1, 1'b1, 1'b1);
  endfunction

  task automatic drive(input logic v, input logic [1:0] sv, input tslot_t s0, input tslot_t s1,
                       input logic fl, input logic [1:0] wbv, input int wb0, input int wb1);
    in_valid      = v;
    in_slot_valid = sv;
    in_rd         = {s1.rd, s0.rd};
    in_rs1        = {s1.rs1, s0.rs1};
    in_rs2        = {s1.rs2, s0.rs2};
    in_wr         = {s1.wr, s0.wr};
    in_use1       = {s1.u1, s0.u1};
    in_use2       = {s1.u2, s0.u2};
    flush         = fl;
    wb_valid      = wbv;
    wb_rd         = {5'(wb1), 5'(wb0)};
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, NOP, NOP, 1'b0, 2'b00, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v  sv     slot0             slot1            fl    wbv    wb0    wb1  | iss   frz   rdy   busy          cnt   issB  frzB
    tbl[0]  = '{1'b1, 2'b11, add(1,2,3),        add(4,5,6),   1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 32'h0000_0000, 6'd0, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'b11, add(5,7,8),        add(9,5,10),  1'b0, 2'b00, 5'd0, 5'd0, 2'b11, 2'b00, 1'b1, 32'h0000_0000, 6'd0, 2'b11, 2'b00};
    tbl[2]  = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b11, 5'd1, 5'd4, 2'b01, 2'b10, 1'b0, 32'h0000_0012, 6'd0, 2'b01, 2'b10};
    tbl[3]  = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b10, 1'b0, 32'h0000_0020, 6'd1, 2'b00, 2'b10};
    tbl[4]  = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b01, 5'd5, 5'd0, 2'b00, 2'b10, 1'b0, 32'h0000_0020, 6'd2, 2'b00, 2'b10};
    tbl[5]  = '{1'b1, 2'b01, mk(7,0,0,1,0,0),   NOP,          1'b0, 2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 1'b1, 32'h0000_0000, 6'd3, 2'b10, 2'b00};
    tbl[6]  = '{1'b1, 2'b01, mk(7,2,0,1,1,0),   NOP,          1'b0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b00, 1'b1, 32'h0000_0200, 6'd3, 2'b01, 2'b00};
    tbl[7]  = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 32'h0000_0080, 6'd3, 2'b00, 2'b01};
    tbl[8]  = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b10, 5'd0, 5'd7, 2'b00, 2'b01, 1'b0, 32'h0000_0080, 6'd4, 2'b00, 2'b01};
    tbl[9]  = '{1'b1, 2'b11, mk(10,7,0,1,1,0),  add(11,12,13),1'b0, 2'b01, 5'd7, 5'd0, 2'b01, 2'b00, 1'b1, 32'h0000_0000, 6'd5, 2'b01, 2'b00};
    tbl[10] = '{1'b0, 2'b00, NOP,               NOP,          1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 32'h0000_0080, 6'd5, 2'b10, 2'b01};

    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].sv, tbl[i].s0, tbl[i].s1, tbl[i].fl, tbl[i].wbv,
            int'(tbl[i].wb0), int'(tbl[i].wb1));
      #1;
      chk($sformatf("row%0d issue", i),    32'(issue),      32'(tbl[i].e_iss));
      chk($sformatf("row%0d freeze", i),   32'(freeze),     32'(tbl[i].e_frz));
      chk($sformatf("row%0d in_ready", i), 32'(in_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("row%0d busy", i),     busy,            tbl[i].e_busy);
      chk($sformatf("row%0d stall_cnt", i),32'(stall_cnt),  32'(tbl[i].e_cnt));
      chk($sformatf("row%0d issue_b", i),  32'(issue_b),    32'(tbl[i].e_issb));
      chk($sformatf("row%0d freeze_b", i), 32'(freeze_b),   32'(tbl[i].e_frzb));
      chk($sformatf("row%0d in_ready_b", i), 32'(in_ready_b), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d busy_b", i),   busy_b,          tbl[i].e_busy);
      cyc();
    end

    // Asynchronous reset while the strict instance is stalled.
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst issue",     32'(issue),     32'h0);
    chk("rst freeze",    32'(freeze),    32'h0);
    chk("rst busy",      busy,           32'h0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst in_ready",  32'(in_ready),  32'h1);
    rst_n = 1'b1;
    #1;

    // Flush with slot1 still held; a bundle presented during flush is accepted.
    drive(1'b1, 2'b11, add(3,1,2), add(4,3,0), 1'b0, 2'b00, 0, 0);
    #1; cyc();
    idle();
    #1;
    chk("raw issue",  32'(issue),  32'h1);
    chk("raw freeze", 32'(freeze), 32'h2);
    cyc();
    drive(1'b1, 2'b01, add(0,1,2), NOP, 1'b1, 2'b00, 0, 0);
    #1;
    chk("flush issue",    32'(issue),    32'h0);
    chk("flush in_ready", 32'(in_ready), 32'h1);
    cyc();
    idle();
    #1;
    chk("post-flush busy kept", busy,         32'h0000_0008);
    chk("post-flush issue",     32'(issue),   32'h1);
    chk("post-flush freeze",    32'(freeze),  32'h0);
    cyc();
    chk("x0 never busy", busy, 32'h0000_0008);

    // Flush forces issue low even for an eligible slot.
    drive(1'b1, 2'b01, add(20,1,2), NOP, 1'b0, 2'b00, 0, 0);
    #1; cyc();
    drive(1'b0, 2'b00, NOP, NOP, 1'b1, 2'b00, 0, 0);
    #1;
    chk("flush eligible issue", 32'(issue),    32'h0);
    chk("flush eligible rdy",   32'(in_ready), 32'h1);
    cyc();
    drive(1'b1, 2'b00, NOP, NOP, 1'b0, 2'b00, 0, 0);
    #1;
    chk("flushed rd not busy", busy, 32'h0000_0008);
    chk("flushed no freeze",   32'(freeze), 32'h0);
    cyc();
    idle();
    #1;
    chk("empty bundle issue",    32'(issue),     32'h0);
    chk("empty bundle freeze",   32'(freeze),    32'h0);
    chk("empty bundle in_ready", 32'(in_ready),  32'h1);
    chk("empty bundle cnt",      32'(stall_cnt), 32'h2);

    // Intra-bundle WAR: slot1 overwrites a register slot0 reads.
    drive(1'b1, 2'b11, mk(21,22,0,1,1,0), mk(22,0,0,1,0,0), 1'b0, 2'b00, 0, 0);
    #1; cyc();
    idle();
    #1;
    chk("war issue",    32'(issue),    32'h1);
    chk("war freeze",   32'(freeze),   32'h2);
    chk("war in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("war drain issue",    32'(issue),    32'h2);
    chk("war drain in_ready", 32'(in_ready), 32'h1);
    cyc();

    // Long stall on busy x3 saturates the counter.
    drive(1'b1, 2'b01, add(23,3,0), NOP, 1'b0, 2'b00, 0, 0);
    #1; cyc();
    idle();
    repeat (80) cyc();
    chk("sat freeze", 32'(freeze),    32'h1);
    chk("sat cnt",    32'(stall_cnt), 32'h3f);
    repeat (5) cyc();
    chk("sat cnt hold", 32'(stall_cnt), 32'h3f);
    drive(1'b0, 2'b00, NOP, NOP, 1'b0, 2'b01, 3, 0);
    #1;
    chk("wb cycle no bypass", 32'(issue), 32'h0);
    cyc();
    idle();
    #1;
    chk("wb release issue", 32'(issue), 32'h1);
    cyc();
    chk("final busy", busy, 32'h00E0_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
